// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst multiplexer and its encoder.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } burst_state_t;

   // Index width for an N-entry one-hot vector; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Position of the lowest set bit; 0 when no bit is set.
   function automatic int onehot_lowest(input logic [31:0] v);
      int idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// Grant encoder: lowest-set-bit index plus a flag for more than one bit set.
module arb_onehot_enc
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic [N-1:0]  i_gnt,
   output logic [SW-1:0] o_idx,
   output logic          o_multi
);

   // Lowest bit wins; clearing it leaves non-zero only if another bit is set.
   always_comb begin
      o_idx   = SW'(onehot_lowest(32'(i_gnt)));
      o_multi = |(i_gnt & (i_gnt - N'(1)));
   end

endmodule

// File: rtl/arb_burst_mux.sv
// Locks the shared output channel to the granted client for one burst and
// forwards its beats over valid/ready, then pulses done to that client.
//
// Handshake: a beat transfers in any cycle where out_valid && out_ready are
// both high at the rising edge; out_valid never looks at out_ready, and the
// client must hold req_data stable until it sees its ack bit.
module arb_burst_mux
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int LW = 4,
   localparam int SW = idx_width(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      gnt,
   input  logic [N-1:0]      req_valid,
   input  logic [N*DW-1:0]   req_data,
   input  logic [N*LW-1:0]   req_len,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DW-1:0]     out_data,
   output logic [SW-1:0]     out_src,
   output logic              out_last,
   output logic [N-1:0]      ack,
   output logic [N-1:0]      done,
   output logic              busy,
   output logic              gnt_err,
   output burst_state_t      dbg_state
);

   burst_state_t    r_state, w_state_nxt;
   logic [SW-1:0]   r_src;
   logic [LW-1:0]   r_len;
   logic [LW-1:0]   r_cnt;
   logic            r_gnt_err;

   logic [SW-1:0]   w_gnt_idx;
   logic            w_gnt_multi;
   logic            w_accept;
   logic            w_last;

   arb_onehot_enc #(.N(N), .SW(SW)) u_enc (
      .i_gnt   (gnt),
      .o_idx   (w_gnt_idx),
      .o_multi (w_gnt_multi)
   );

   // Next-state logic and all channel outputs, decoded from state and inputs.
   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      ack         = '0;
      done        = '0;
      w_last      = (r_cnt == r_len);
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (gnt != '0) w_state_nxt = XFER;
         end
         XFER: begin
            out_valid = req_valid[r_src];
            out_data  = req_data[r_src*DW +: DW];
            out_last  = w_last;
            w_accept  = out_valid && out_ready;
            if (w_accept) begin
               ack[r_src] = 1'b1;
               if (w_last) w_state_nxt = DONE;
            end
         end
         DONE: begin
            done[r_src] = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, owner, length, beat counter and sticky grant error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_src     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_gnt_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && gnt != '0) begin
            r_src <= w_gnt_idx;
            r_len <= req_len[w_gnt_idx*LW +: LW];
            r_cnt <= '0;
            if (w_gnt_multi) r_gnt_err <= 1'b1;
         end else if (w_accept && !w_last) begin
            // The final beat leaves cnt at len so it can never wrap.
            r_cnt <= r_cnt + LW'(1);
         end
      end
   end

   assign out_src   = r_src;
   assign busy      = (r_state != IDLE);
   assign gnt_err   = r_gnt_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_arb_burst_mux.sv
// Directed bench for arb_burst_mux: bursts, backpressure, valid gaps,
// ignored grants, multi-hot grants, async reset and the longest burst.
module tb_arb_burst_mux;
   import arb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int SW = 2;

   logic            clk;
   logic            rst;
   logic [N-1:0]    gnt;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N*LW-1:0] req_len;
   logic            out_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;
   logic            out_last;
   logic [N-1:0]    ack;
   logic [N-1:0]    done;
   logic            busy;
   logic            gnt_err;
   burst_state_t    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   arb_burst_mux #(.N(N), .DW(DW), .LW(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .gnt       (gnt),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_len   (req_len),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .ack       (ack),
      .done      (done),
      .busy      (busy),
      .gnt_err   (gnt_err),
      .dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Beat payload: client in bits 23:16, beat number in low byte.
   function automatic logic [DW-1:0] beat_data(input int c, input int k);
      return 32'hD000_0000 | (32'(c) << 16) | 32'(k & 8'hFF);
   endfunction

   // Owner gets beat k, every other client carries an 0xEE marker.
   task automatic load_data(input int c, input int k);
      for (int i = 0; i < N; i++)
         req_data[i*DW +: DW] = (i == c) ? beat_data(c, k) : beat_data(i, 8'hEE);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full burst. Called just after a rising edge. stall_kind 0 drops
   // out_ready, 1 drops the owner's req_valid, for stall_n cycles at beat stall_beat.
   task automatic burst(input int c, input int len, input logic [N-1:0] g,
                        input logic [N-1:0] late_gnt, input logic [N-1:0] done_gnt,
                        input int stall_beat, input int stall_n, input int stall_kind);
      int k;
      int stalls;
      int guard;
      logic stall;
      gnt = g;
      req_len[c*LW +: LW] = LW'(len);
      req_valid = '1;
      out_ready = 1'b1;
      load_data(c, 0);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_data", out_data, 0);
      tick();
      gnt = late_gnt;
      k = 0;
      stalls = 0;
      guard = 0;
      while (k <= len && guard < 64) begin
         guard++;
         stall = (k == stall_beat) && (stalls < stall_n);
         out_ready = !(stall && stall_kind == 0);
         req_valid[c] = !(stall && stall_kind == 1);
         @(negedge clk);
         chk("x_busy", busy, 1);
         chk("x_src", out_src, c);
         chk("x_valid", out_valid, !(stall && stall_kind == 1));
         chk("x_data", out_data, beat_data(c, k));
         chk("x_last", out_last, k == len);
         chk("x_ack", ack, stall ? 0 : (1 << c));
         chk("x_done", done, 0);
         tick();
         gnt = '0;
         if (stall) stalls++;
         else begin
            k++;
            load_data(c, k);
         end
      end
      chk("x_beats", k, len + 1);
      out_ready = 1'b1;
      req_valid = '1;
      gnt = done_gnt;
      @(negedge clk);
      chk("d_done", done, 1 << c);
      chk("d_busy", busy, 1);
      chk("d_valid", out_valid, 0);
      chk("d_ack", ack, 0);
      chk("d_last", out_last, 0);
      tick();
      gnt = '0;
      @(negedge clk);
      chk("i_done", done, 0);
      chk("i_busy", busy, 0);
      chk("i_state", dbg_state, IDLE);
      tick();
      @(negedge clk);
      chk("i2_busy", busy, 0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      gnt = '0;
      req_valid = '0;
      req_data = '0;
      req_len = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", gnt_err, 0);
      chk("rst_src", out_src, 0);
      chk("rst_state", dbg_state, IDLE);
      rst = 1'b0;
      tick();

      // Plain 4-beat burst on client 1.
      burst(1, 3, 4'b0010, 4'b0000, 4'b0000, -1, 0, 0);
      // Same with two cycles of sink backpressure at beat 2.
      burst(1, 3, 4'b0010, 4'b0000, 4'b0000, 2, 2, 0);
      // Client valid gap of one cycle at beat 1.
      burst(1, 3, 4'b0010, 4'b0000, 4'b0000, 1, 1, 1);
      // Grant to client 3 during the burst is ignored; one during DONE is dropped.
      burst(0, 2, 4'b0001, 4'b1000, 4'b0100, -1, 0, 0);
      chk("t3_err", gnt_err, 0);
      burst(3, 1, 4'b1000, 4'b0000, 4'b0000, -1, 0, 0);
      // Multi-hot grant takes the lowest bit and sets the sticky error.
      burst(1, 0, 4'b0110, 4'b0000, 4'b0000, -1, 0, 0);
      chk("t4_err", gnt_err, 1);
      burst(2, 1, 4'b0100, 4'b0000, 4'b0000, -1, 0, 0);
      chk("t4_sticky", gnt_err, 1);

      // Async reset in the middle of beat 2 of a 4-beat burst.
      gnt = 4'b0001;
      req_len[0 +: LW] = LW'(3);
      load_data(0, 0);
      tick();
      gnt = '0;
      tick();
      load_data(0, 1);
      tick();
      load_data(0, 2);
      @(negedge clk);
      chk("r_pre_valid", out_valid, 1);
      chk("r_pre_data", out_data, beat_data(0, 2));
      #2 rst = 1'b1;
      #1;
      chk("r_valid", out_valid, 0);
      chk("r_data", out_data, 0);
      chk("r_last", out_last, 0);
      chk("r_ack", ack, 0);
      chk("r_done", done, 0);
      chk("r_busy", busy, 0);
      chk("r_src", out_src, 0);
      chk("r_err", gnt_err, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("r_post_state", dbg_state, IDLE);
      chk("r_post_done", done, 0);
      tick();
      @(negedge clk);
      chk("r_post_done2", done, 0);
      chk("r_post_busy", busy, 0);
      tick();

      // Longest burst: 16 beats on client 2, last only on the 16th.
      burst(2, 15, 4'b0100, 4'b0000, 4'b0000, -1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
